// File: rtl/piso_stream_if.sv
// Load/serial handshake bundle for piso_stream.
// master = word producer plus serial sink, slave = the shifter.
interface piso_stream_if #(
  parameter int WIDTH = 8
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_data;
  logic             msb_first;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_data;
  logic             ser_last;

  modport master (
    output load_valid, load_data, msb_first, ser_ready,
    input  load_ready, ser_valid, ser_data, ser_last
  );

  modport slave (
    input  load_valid, load_data, msb_first, ser_ready,
    output load_ready, ser_valid, ser_data, ser_last
  );
endinterface

// File: rtl/piso_stream.sv
// Parametrised PISO with valid/ready on both sides, MSB/LSB-first per word.
// Define PISO_STREAM_PARITY_EN to append an even-parity bit to each frame.
module piso_stream #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input logic         clk,
  input logic         clear_n,
  piso_stream_if.slave bus
);

`ifdef PISO_STREAM_PARITY_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] sr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             msb_q;
`ifdef PISO_STREAM_PARITY_EN
  logic             par_q;
`endif

  logic sv_valid;
  logic sv_data;
  logic sv_last;
  logic bit_sel;
  logic xfer;
  logic last_xfer;
  logic load_rdy;
  logic accept;

  assign xfer      = sv_valid && bus.ser_ready;
  assign last_xfer = xfer && sv_last;
  assign load_rdy  = (state_q == IDLE) || last_xfer;
  assign accept    = bus.load_valid && load_rdy;

`ifdef PISO_STREAM_PARITY_EN
  // Parity goes out after all data bits, from its own register.
  assign bit_sel = (cnt_q == CNT_W'(WIDTH)) ? par_q
                 : (msb_q ? sr_q[WIDTH-1] : sr_q[0]);
`else
  assign bit_sel = msb_q ? sr_q[WIDTH-1] : sr_q[0];
`endif

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept) state_d = SHIFT;
      SHIFT: if (last_xfer && !accept) state_d = IDLE;
    endcase
  end

  always_comb begin
    sv_valid = 1'b0;
    sv_data  = 1'b0;
    sv_last  = 1'b0;
    unique case (state_q)
      IDLE: ;
      SHIFT: begin
        sv_valid = 1'b1;
        sv_data  = bit_sel;
        sv_last  = (cnt_q == LAST);
      end
    endcase
  end

  // Count stops at LAST; only a reload brings it back to zero.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      sr_q  <= '0;
      cnt_q <= '0;
      msb_q <= 1'b0;
    end else if (accept) begin
      sr_q  <= bus.load_data;
      cnt_q <= '0;
      msb_q <= bus.msb_first;
    end else if (xfer) begin
      sr_q <= msb_q ? {sr_q[WIDTH-2:0], 1'b0}
                    : {1'b0, sr_q[WIDTH-1:1]};
      if (!sv_last) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

`ifdef PISO_STREAM_PARITY_EN
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^bus.load_data;
    end
  end
`endif

  assign bus.load_ready = load_rdy;
  assign bus.ser_valid  = sv_valid;
  assign bus.ser_data   = sv_data;
  assign bus.ser_last   = sv_last;

endmodule

// File: tb/tb_piso_stream.sv
// Self-checking bench for piso_stream against a bit-list reference model.
// Build with +define+PISO_STREAM_PARITY_EN to exercise the parity frame.
module tb_piso_stream;
  localparam int W = 8;
`ifdef PISO_STREAM_PARITY_EN
  localparam int F = W + 1;
`else
  localparam int F = W;
`endif

  typedef bit bq_t[$];

  logic clk;
  logic clear_n;
  int   n_cmp;
  int   n_bad;

  bq_t  obs_d;
  bq_t  obs_l;
  int   obs_cyc;
  int   obs_lr_bad;
  int   obs_hold_bad;
  bit   obs_hold_data;
  logic obs_end_valid;
  logic obs_end_data;

  piso_stream_if #(.WIDTH(W)) bus ();

  piso_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame = data bits in transmit order, then parity when enabled.
  function automatic bq_t model(logic [W-1:0] w, bit m);
    bq_t q;
    int  idx;
    for (int i = 0; i < W; i++) begin
      idx = m ? (W - 1 - i) : i;
      q.push_back(bit'((w >> idx) & 1));
    end
`ifdef PISO_STREAM_PARITY_EN
    q.push_back(^w);
`endif
    return q;
  endfunction

  function automatic logic [63:0] pack(bq_t q);
    logic [63:0] r = '0;
    for (int i = 0; i < q.size() && i < 64; i++) r[i] = q[i];
    return r;
  endfunction

  // Loads one word, optionally stalls, records the serial stream.
  task automatic drive_frame(input logic [W-1:0] w, input bit m,
                             input int stall_after, input int stall_len);
    int n;
    int sent;
    int stalled;
    bit hl;
    obs_d.delete();
    obs_l.delete();
    obs_lr_bad   = 0;
    obs_hold_bad = 0;
    obs_hold_data = 1'b0;
    hl = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_data  = w;
    bus.msb_first  = m;
    bus.ser_ready  = 1'b1;
    n = 0;
    while (!bus.load_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    bus.load_data  = W'($urandom);
    bus.msb_first  = 1'($urandom);
    sent    = 0;
    stalled = 0;
    obs_cyc = 0;
    while (bus.ser_valid && obs_cyc < 64) begin
      obs_cyc++;
      bus.ser_ready = !(sent == stall_after && stalled < stall_len);
      #1;
      if (bus.load_ready !== (bus.ser_ready && bus.ser_last))
        obs_lr_bad++;
      if (bus.ser_ready) begin
        obs_d.push_back(bus.ser_data);
        obs_l.push_back(bus.ser_last);
        sent++;
      end else begin
        if (stalled == 0) begin
          obs_hold_data = bus.ser_data;
          hl = bus.ser_last;
        end else if (bus.ser_data !== obs_hold_data
                     || bus.ser_last !== hl) begin
          obs_hold_bad++;
        end
        stalled++;
      end
      @(posedge clk); #1;
    end
    bus.ser_ready = 1'b1;
    obs_end_valid = bus.ser_valid;
    obs_end_data  = bus.ser_data;
  endtask

  task automatic test_reset;
    clear_n = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.msb_first  = 1'b0;
    bus.ser_ready  = 1'b1;
    #3;
    n_cmp++;
    if ({bus.ser_valid, bus.ser_data, bus.ser_last, bus.load_ready}
        !== 4'b0001) begin
      n_bad++;
      $display("FAIL reset_outputs: got %b want 0001",
               {bus.ser_valid, bus.ser_data, bus.ser_last, bus.load_ready});
    end
    #14 clear_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ser_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release: got v=%b r=%b want v=0 r=1",
               bus.ser_valid, bus.load_ready);
    end
  endtask

  task automatic test_msb;
    bq_t e = model(8'hA5, 1'b1);
    drive_frame(8'hA5, 1'b1, -1, 0);
    n_cmp++;
    if (pack(obs_d) !== pack(e) || obs_d.size() != F) begin
      n_bad++;
      $display("FAIL msb_bits: got %h/%0d want %h/%0d",
               pack(obs_d), obs_d.size(), pack(e), F);
    end
    n_cmp++;
    if (pack(obs_l) !== (64'd1 << (F - 1))) begin
      n_bad++;
      $display("FAIL msb_last: got %h want %h",
               pack(obs_l), 64'd1 << (F - 1));
    end
    n_cmp++;
    if (obs_lr_bad != 0) begin
      n_bad++;
      $display("FAIL msb_load_ready: got %0d bad cycles want 0",
               obs_lr_bad);
    end
  endtask

  task automatic test_lsb;
    bq_t e = model(8'h1E, 1'b0);
    drive_frame(8'h1E, 1'b0, -1, 0);
    n_cmp++;
    if (pack(obs_d) !== pack(e) || obs_d.size() != F) begin
      n_bad++;
      $display("FAIL lsb_bits: got %h/%0d want %h/%0d",
               pack(obs_d), obs_d.size(), pack(e), F);
    end
    n_cmp++;
    if (obs_cyc != F || obs_end_valid !== 1'b0 || obs_end_data !== 1'b0) begin
      n_bad++;
      $display("FAIL lsb_end: got cyc=%0d v=%b d=%b want cyc=%0d v=0 d=0",
               obs_cyc, obs_end_valid, obs_end_data, F);
    end
  endtask

  task automatic test_backpressure;
    bq_t e = model(8'hA5, 1'b1);
    drive_frame(8'hA5, 1'b1, 2, 3);
    n_cmp++;
    if (pack(obs_d) !== pack(e) || obs_d.size() != F) begin
      n_bad++;
      $display("FAIL bp_bits: got %h/%0d want %h/%0d",
               pack(obs_d), obs_d.size(), pack(e), F);
    end
    n_cmp++;
    if (obs_cyc != F + 3) begin
      n_bad++;
      $display("FAIL bp_cycles: got %0d want %0d", obs_cyc, F + 3);
    end
    n_cmp++;
    if (obs_hold_bad != 0 || obs_hold_data !== e[2]) begin
      n_bad++;
      $display("FAIL bp_hold: got bad=%0d d=%b want bad=0 d=%b",
               obs_hold_bad, obs_hold_data, e[2]);
    end
    n_cmp++;
    if (obs_lr_bad != 0) begin
      n_bad++;
      $display("FAIL bp_load_ready: got %0d bad cycles want 0", obs_lr_bad);
    end
  endtask

  task automatic test_back_to_back;
    bq_t e = model(8'hA5, 1'b1);
    bq_t e2 = model(8'h3C, 1'b1);
    bq_t d;
    int  k;
    int  acc;
    foreach (e2[i]) e.push_back(e2[i]);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hA5;
    bus.msb_first  = 1'b1;
    bus.ser_ready  = 1'b1;
    @(posedge clk); #1;
    bus.load_data = 8'h3C;
    k   = 0;
    acc = 0;
    while (bus.ser_valid && k < 64) begin
      k++;
      d.push_back(bus.ser_data);
      if (bus.load_valid && bus.load_ready) acc = k;
      @(posedge clk); #1;
      if (acc == k) begin
        bus.load_valid = 1'b0;
        bus.load_data  = W'($urandom);
      end
    end
    n_cmp++;
    if (k != 2 * F) begin
      n_bad++;
      $display("FAIL b2b_cycles: got %0d want %0d", k, 2 * F);
    end
    n_cmp++;
    if (pack(d) !== pack(e)) begin
      n_bad++;
      $display("FAIL b2b_bits: got %h want %h", pack(d), pack(e));
    end
    n_cmp++;
    if (acc != F) begin
      n_bad++;
      $display("FAIL b2b_accept: got cycle %0d want %0d", acc, F);
    end
  endtask

  task automatic test_midframe_reset;
    bq_t e = model(8'h0F, 1'b1);
    bus.load_valid = 1'b1;
    bus.load_data  = 8'hFF;
    bus.msb_first  = 1'b1;
    bus.ser_ready  = 1'b1;
    @(posedge clk); #1;
    bus.load_valid = 1'b0;
    repeat (4) @(posedge clk);
    #3 clear_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.ser_valid, bus.ser_data, bus.ser_last, bus.load_ready}
        !== 4'b0001) begin
      n_bad++;
      $display("FAIL midreset_outputs: got %b want 0001",
               {bus.ser_valid, bus.ser_data, bus.ser_last, bus.load_ready});
    end
    #2 clear_n = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (bus.ser_valid !== 1'b0 || bus.load_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_after: got v=%b r=%b want v=0 r=1",
               bus.ser_valid, bus.load_ready);
    end
    drive_frame(8'h0F, 1'b1, -1, 0);
    n_cmp++;
    if (pack(obs_d) !== pack(e) || obs_d.size() != F) begin
      n_bad++;
      $display("FAIL midreset_reload: got %h/%0d want %h/%0d",
               pack(obs_d), obs_d.size(), pack(e), F);
    end
  endtask

`ifdef PISO_STREAM_PARITY_EN
  task automatic test_parity;
    drive_frame(8'hA5, 1'b1, -1, 0);
    n_cmp++;
    if (obs_d.size() != F || obs_d[F-1] !== 1'b0
        || pack(obs_l) !== (64'd1 << (F - 1))) begin
      n_bad++;
      $display("FAIL parity_a5: got bits %h last %h want par 0 last %h",
               pack(obs_d), pack(obs_l), 64'd1 << (F - 1));
    end
    drive_frame(8'h07, 1'b0, -1, 0);
    n_cmp++;
    if (obs_d.size() != F || obs_d[F-1] !== 1'b1) begin
      n_bad++;
      $display("FAIL parity_07: got bits %h size %0d want par 1",
               pack(obs_d), obs_d.size());
    end
  endtask
`endif

  task automatic test_random;
    logic [W-1:0] w;
    bit           m;
    int           sa;
    int           sl;
    bq_t          e;
    for (int i = 0; i < 16; i++) begin
      w  = W'($urandom);
      m  = 1'($urandom);
      sa = $urandom_range(0, F - 1);
      sl = $urandom_range(0, 3);
      e  = model(w, m);
      drive_frame(w, m, sa, sl);
      n_cmp++;
      if (pack(obs_d) !== pack(e) || obs_cyc != F + sl
          || obs_hold_bad != 0 || obs_lr_bad != 0) begin
        n_bad++;
        $display("FAIL rand_%0d w=%h m=%b: got %h cyc=%0d hb=%0d lb=%0d want %h cyc=%0d",
                 i, w, m, pack(obs_d), obs_cyc, obs_hold_bad, obs_lr_bad,
                 pack(e), F + sl);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_msb();
    test_lsb();
    test_backpressure();
    test_back_to_back();
    test_midframe_reset();
`ifdef PISO_STREAM_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in serial-out shifter; successor to the fixed 4-bit PISO.
- Generic WIDTH, per-word MSB/LSB-first selection, and a valid/ready handshake on both the parallel load side and the serial side.
- Supports back-to-back words with no idle gap and backpressure.
- Sits between a parallel word producer and a bit-serial link or serialiser stage.

Parameters:
- WIDTH, 8, bits per parallel word; legal range WIDTH >= 2.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset; deassertion synchronised to clk externally
- load_valid  input  1  load_data and msb_first are valid
- load_ready  output  1  block can accept a word this cycle
- load_data  input  WIDTH  parallel word to serialise
- msb_first  input  1  1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first; sampled with the word
- ser_valid  output  1  ser_data holds a valid bit
- ser_ready  input  1  downstream accepts the current bit
- ser_data  output  1  serial bit
- ser_last  output  1  current bit is the final bit of the frame

Behaviour:
- Reset (clear_n low, acts immediately):
  - state = IDLE; shift register = 0; count = 0; mode register = 0.
  - Outputs: ser_valid = 0, ser_data = 0, ser_last = 0, load_ready = 1.
- State machine has two states, IDLE and SHIFT.
- Load acceptance:
  - load_ready = (state == IDLE) || (ser_valid && ser_ready && ser_last). This is the only combinational input-to-output path.
  - A load is accepted at a posedge where load_valid && load_ready.
  - On acceptance: shift register <= load_data, mode register <= msb_first, count <= 0, state <= SHIFT.
- Latency: the first bit is on ser_data with ser_valid = 1 in the cycle after acceptance.
- SHIFT:
  - ser_valid = 1.
  - ser_data = sr[WIDTH-1] when mode = MSB-first, otherwise sr[0].
  - ser_last = (count == FRAME-1), where FRAME = WIDTH, or WIDTH+1 with parity enabled.
- Bit transfer:
  - A bit transfers when ser_valid && ser_ready.
  - On transfer: shift toward the output end (left for MSB-first, right for LSB-first, zero-fill) and count <= count+1.
- Backpressure: while ser_ready = 0, ser_data, ser_last, count and shift register hold unchanged.
- End of frame:
  - When the last bit transfers and load_valid = 1, the new word loads in the same edge. Its first bit appears the next cycle, so there is no ser_valid gap.
  - When the last bit transfers and load_valid = 0, state <= IDLE, ser_valid = 0 and ser_data = 0.
- load_data and msb_first changes during SHIFT are ignored until the next acceptance.
- ser_data, ser_valid and ser_last are functions of state registers only.
- Reset mid-frame: the partial word is discarded with no further bits. After release, the block is in IDLE and ready.
- Count never exceeds FRAME-1 and wraps to 0 only through a reload.

Optional Feature:
- Macro: PISO_STREAM_PARITY_EN.
- Defined:
  - The frame carries WIDTH+1 bits. The extra bit follows the data and is even parity (XOR of all WIDTH bits of the loaded word), computed at load and stored in a parity register.
  - ser_last asserts on the parity bit only.
  - Reset clears the parity register to 0.
- Undefined: the frame is WIDTH bits; no parity logic is present.

Test Plan:
- Reset: drive clear_n = 0 mid-simulation at a non-clock-edge time -> ser_valid = 0, ser_data = 0, ser_last = 0 and load_ready = 1 immediately.
- MSB-first, WIDTH = 8, ser_ready = 1:
  - Load 0xA5 with msb_first = 1 -> bits 1,0,1,0,0,1,0,1 on cycles 1-8 after acceptance.
  - ser_last only on cycle 8; load_ready = 0 on cycles 1-7.
- LSB-first: load 0x1E with msb_first = 0 -> bits 0,1,1,1,1,0,0,0; ser_valid falls on cycle 9.
- Backpressure: load 0xA5 MSB-first and drop ser_ready for 3 cycles after bit 3 -> ser_data holds 1 and count holds; the remaining bits resume in order and the total frame takes 11 cycles.
- Back-to-back:
  - Load 0xA5 then hold load_valid with 0x3C -> 16 consecutive ser_valid cycles, bits 10100101 00111100.
  - Second acceptance occurs on the first word's ser_last cycle.
- Mid-frame reset plus parity:
  - Assert clear_n low after bit 4 of 0xFF -> ser_valid drops at once. After release, load 0x0F MSB-first -> bits 00001111.
  - With PISO_STREAM_PARITY_EN, load 0xA5 -> 9th bit = 0 with ser_last. Load 0x07 -> 9th bit = 1.
